clock_set_ctrl: RTL

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_pkg.sv | 30 +++
 rtl/clock_btn_debounce.sv | 75 +++++++
 rtl/clock_set_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock-setting controller.
//
// Contents:
//   state_e        FSM states: RUN, SET_HH, SET_MM, SET_SS, COMMIT
//   HH_MAX/MM_MAX/SS_MAX  largest legal value of each time field
//   BLANK_HH/MM/SS bit positions of each display pair in blank_mask
//   isSetState()   true for the three field-edit states
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_HH = 3'd1,
    ST_SET_MM = 3'd2,
    ST_SET_SS = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam logic [4:0] HH_MAX = 5'd23;
  localparam logic [5:0] MM_MAX = 6'd59;
  localparam logic [5:0] SS_MAX = 6'd59;

  localparam int BLANK_HH = 2;
  localparam int BLANK_MM = 1;
  localparam int BLANK_SS = 0;

  function automatic logic isSetState(input state_e s);
    return (s == ST_SET_HH) || (s == ST_SET_MM) || (s == ST_SET_SS);
  endfunction

endpackage

// File: rtl/clock_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, level debouncer and press detector.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-low
//   btn_i    in   raw active-high button, asynchronous to clk
//   press_o  out  one-cycle pulse on a rising edge of the debounced level
//
// Parameter:
//   DEBOUNCE_CYCLES  consecutive equal synchronized samples needed before a
//                    new level is accepted
module clock_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;

  // The synchronizer flops are deliberately left out of reset so that they
  // keep tracking the real pin level while reset is held; this is what lets
  // the arming logic see a button that is held through reset release.
  always_ff @(posedge clk) begin
    sync1_q <= btn_i;
    sync2_q <= sync1_q;
  end

  // Count consecutive samples that disagree with the accepted level and flip
  // the accepted level once enough have been seen. A press is only reported
  // once the synchronized input has been observed low after reset (armed),
  // so a button held through reset needs a release and a fresh press.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    armed_d = armed_q | ~sync2_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q & armed_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: lets a user stop the timekeeping counter, edit
// hours, minutes and seconds with a mode and an increment button, and load
// the edited time back into the counter.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-low reset
//   btn_mode, btn_inc       raw active-high buttons, asynchronous
//   tick_1hz                one-cycle pulse per second
//   cur_hh/cur_mm/cur_ss    current time from the counter (5/6/6 bits)
//   run_en                  1 = counter may advance
//   load, load_ack          load request / acknowledge handshake
//   set_hh/set_mm/set_ss    edit values (5/6/6 bits, binary)
//   blank_mask              {HH, MM, SS}; 1 blanks that display pair
//
// Configuration macro:
//   CLOCK_SET_TIMEOUT_EN    abandon an edit after TIMEOUT_S idle seconds
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int BLINK_HALF_CYCLES = 12_500_000,
  parameter int TIMEOUT_S         = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hh,
  input  logic [5:0] cur_mm,
  input  logic [5:0] cur_ss,
  output logic       run_en,
  output logic       load,
  input  logic       load_ack,
  output logic [4:0] set_hh,
  output logic [5:0] set_mm,
  output logic [5:0] set_ss,
  output logic [2:0] blank_mask
);

  localparam int BW = $clog2(BLINK_HALF_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

  logic modePress, incPress, incTaken;

  state_e        state_q, state_d;
  logic          runEn_q, runEn_d;
  logic          load_q, load_d;
  logic [4:0]    setHh_q, setHh_d;
  logic [5:0]    setMm_q, setMm_d;
  logic [5:0]    setSs_q, setSs_d;
  logic [2:0]    blankMask_q, blankMask_d;
  logic [BW-1:0] blinkCnt_q, blinkCnt_d;
  logic          blinkPhase_q, blinkPhase_d;

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_S - 1);
  logic [TW-1:0] timeoutCnt_q, timeoutCnt_d;
`else
  logic unusedCfg;
  assign unusedCfg = tick_1hz ^ (TIMEOUT_S != 0);
`endif

  clock_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uModeBtn (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_mode),
    .press_o (modePress)
  );

  clock_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uIncBtn (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_inc),
    .press_o (incPress)
  );

  // Next-state logic for the edit FSM, the blink generator and the optional
  // idle timeout. Every output is computed here from the next state so it
  // can be registered alongside the state itself.
  always_comb begin
    state_d  = state_q;
    runEn_d  = runEn_q;
    load_d   = load_q;
    setHh_d  = setHh_q;
    setMm_d  = setMm_q;
    setSs_d  = setSs_q;
    incTaken = 1'b0;

    // Mode is checked first in every edit state so a simultaneous inc press
    // is dropped rather than applied to the field being left.
    case (state_q)
      ST_RUN: begin
        runEn_d = 1'b1;
        load_d  = 1'b0;
        if (modePress) begin
          state_d = ST_SET_HH;
          runEn_d = 1'b0;
          setHh_d = cur_hh;
          setMm_d = cur_mm;
          setSs_d = cur_ss;
        end
      end
      ST_SET_HH: begin
        runEn_d = 1'b0;
        load_d  = 1'b0;
        if (modePress) begin
          state_d = ST_SET_MM;
        end else if (incPress) begin
          setHh_d  = (setHh_q == HH_MAX) ? '0 : setHh_q + 5'd1;
          incTaken = 1'b1;
        end
      end
      ST_SET_MM: begin
        runEn_d = 1'b0;
        load_d  = 1'b0;
        if (modePress) begin
          state_d = ST_SET_SS;
        end else if (incPress) begin
          setMm_d  = (setMm_q == MM_MAX) ? '0 : setMm_q + 6'd1;
          incTaken = 1'b1;
        end
      end
      ST_SET_SS: begin
        runEn_d = 1'b0;
        load_d  = 1'b0;
        if (modePress) begin
          state_d = ST_COMMIT;
          load_d  = 1'b1;
        end else if (incPress) begin
          setSs_d  = (setSs_q == SS_MAX) ? '0 : setSs_q + 6'd1;
          incTaken = 1'b1;
        end
      end
      ST_COMMIT: begin
        runEn_d = 1'b0;
        load_d  = 1'b1;
        if (load_ack) begin
          state_d = ST_RUN;
          load_d  = 1'b0;
          runEn_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        runEn_d = 1'b1;
        load_d  = 1'b0;
      end
    endcase

`ifdef CLOCK_SET_TIMEOUT_EN
    // Idle seconds are counted only while editing; any press restarts the
    // count, and the last tick abandons the edit without a load.
    timeoutCnt_d = '0;
    if (isSetState(state_q)) begin
      if (modePress || incPress) begin
        timeoutCnt_d = '0;
      end else if (tick_1hz) begin
        if (timeoutCnt_q == TIMEOUT_LAST) begin
          state_d = ST_RUN;
          runEn_d = 1'b1;
          load_d  = 1'b0;
        end else begin
          timeoutCnt_d = timeoutCnt_q + TW'(1);
        end
      end else begin
        timeoutCnt_d = timeoutCnt_q;
      end
    end
`endif

    // The blink restarts visible on every state change and every accepted
    // increment so the user always sees the new value immediately.
    if (!isSetState(state_d) || (state_d != state_q) || incTaken) begin
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b0;
    end else if (blinkCnt_q == BLINK_LAST) begin
      blinkCnt_d   = '0;
      blinkPhase_d = ~blinkPhase_q;
    end else begin
      blinkCnt_d   = blinkCnt_q + BW'(1);
      blinkPhase_d = blinkPhase_q;
    end

    blankMask_d = '0;
    case (state_d)
      ST_SET_HH: blankMask_d[BLANK_HH] = blinkPhase_d;
      ST_SET_MM: blankMask_d[BLANK_MM] = blinkPhase_d;
      ST_SET_SS: blankMask_d[BLANK_SS] = blinkPhase_d;
      default:   blankMask_d = '0;
    endcase
  end

  // State and registered outputs. Reset drops any edit in progress,
  // including a pending load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      runEn_q      <= 1'b1;
      load_q       <= 1'b0;
      setHh_q      <= '0;
      setMm_q      <= '0;
      setSs_q      <= '0;
      blankMask_q  <= '0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
      timeoutCnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      runEn_q      <= runEn_d;
      load_q       <= load_d;
      setHh_q      <= setHh_d;
      setMm_q      <= setMm_d;
      setSs_q      <= setSs_d;
      blankMask_q  <= blankMask_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
`ifdef CLOCK_SET_TIMEOUT_EN
      timeoutCnt_q <= timeoutCnt_d;
`endif
    end
  end

  assign run_en     = runEn_q;
  assign load       = load_q;
  assign set_hh     = setHh_q;
  assign set_mm     = setMm_q;
  assign set_ss     = setSs_q;
  assign blank_mask = blankMask_q;

endmodule
